uart_rx_data_sampler: RTL and testbench

- Upstream companion of the UART RX control FSM.
- Oversamples rx_in with an edge counter and a bit counter, and exports both counts to the FSM (edge_cnt_in, bit_cnt_in).
- Produces a 3-point majority-voted bit per UART bit period for the FSM and for the deserializer, parity checker and stop/start checkers.
- Sits between the RX pin (or its synchronizer) and the FSM/deserializer, in the UART_RX clock domain.

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/uart_rx_edge_bit_counter.sv | 50 +++++
 rtl/uart_rx_data_sampler.sv | 86 ++++++++
 tb/tb_uart_rx_data_sampler.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART RX data path.
// Holds counter widths, prescale floor, bit indices and majority3.
package uart_rx_pkg;

  localparam int EDGE_W       = 5;
  localparam int BIT_W        = 4;
  localparam int MIN_PRESCALE = 4;

  localparam logic [BIT_W-1:0] START_BIT      = 4'd0;
  localparam logic [BIT_W-1:0] FIRST_DATA_BIT = 4'd1;
  localparam logic [BIT_W-1:0] LAST_DATA_BIT  = 4'd8;
  localparam logic [BIT_W-1:0] LAST_BIT_PAR   = 4'd10;
  localparam logic [BIT_W-1:0] LAST_BIT_NOPAR = 4'd9;

  function automatic logic majority3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Edge-within-bit and bit-within-frame counters for UART RX.
// Ports: clk, reset_n, counter_en, par_en, prescale (already clamped) -> edge_cnt, bit_cnt.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              counter_en,
  input  logic              par_en,
  input  logic [EDGE_W-1:0] prescale,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt
);

  logic             wrap;
  logic [BIT_W-1:0] last;

  assign last = par_en ? LAST_BIT_PAR : LAST_BIT_NOPAR;

  // >= rather than == so a prescale change mid-bit cannot overrun
  assign wrap = (edge_cnt >= (prescale - EDGE_W'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cnt <= '0;
    end else if (!counter_en) begin
      edge_cnt <= '0;
    end else if (wrap) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + EDGE_W'(1);
    end
  end

  // >= last also recovers when par_en drops with the count at 10
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= START_BIT;
    end else if (!counter_en) begin
      bit_cnt <= START_BIT;
    end else if (wrap) begin
      if (bit_cnt >= last) begin
        bit_cnt <= START_BIT;
      end else begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_data_sampler.sv
// UART RX oversampler: counters plus 3-point majority vote per bit.
// Ports: clk, reset_n, rx_in, prescale_in, par_en_in, counter_en_in,
//   data_sample_en_in -> edge_cnt_out, bit_cnt_out, sampled_bit_out,
//   sample_valid_out. Macro UART_RX_SYNC_EN adds a 2-flop rx synchronizer.
module uart_rx_data_sampler
  import uart_rx_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_in,
  input  logic [EDGE_W-1:0] prescale_in,
  input  logic              par_en_in,
  input  logic              counter_en_in,
  input  logic              data_sample_en_in,
  output logic [EDGE_W-1:0] edge_cnt_out,
  output logic [BIT_W-1:0]  bit_cnt_out,
  output logic              sampled_bit_out,
  output logic              sample_valid_out
);

  logic [EDGE_W-1:0] p_eff;
  logic [EDGE_W-1:0] half;
  logic [EDGE_W-1:0] pt0;
  logic [EDGE_W-1:0] pt1;
  logic [EDGE_W-1:0] pt2;
  logic              rx_s;
  logic              s0;
  logic              s1;

  assign p_eff = (prescale_in < EDGE_W'(MIN_PRESCALE))
               ? EDGE_W'(MIN_PRESCALE) : prescale_in;
  assign half  = p_eff >> 1;
  assign pt0   = half - EDGE_W'(1);
  assign pt1   = half;
  assign pt2   = half + EDGE_W'(1);

`ifdef UART_RX_SYNC_EN
  logic sync0;
  logic sync1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0 <= 1'b1;
      sync1 <= 1'b1;
    end else begin
      sync0 <= rx_in;
      sync1 <= sync0;
    end
  end

  assign rx_s = sync1;
`else
  assign rx_s = rx_in;
`endif

  uart_rx_edge_bit_counter u_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .counter_en (counter_en_in),
    .par_en     (par_en_in),
    .prescale   (p_eff),
    .edge_cnt   (edge_cnt_out),
    .bit_cnt    (bit_cnt_out)
  );

  // third sample is the live line at pt2, voted straight into the output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0               <= 1'b1;
      s1               <= 1'b1;
      sampled_bit_out  <= 1'b1;
      sample_valid_out <= 1'b0;
    end else begin
      sample_valid_out <= 1'b0;
      if (data_sample_en_in) begin
        if (edge_cnt_out == pt0) s0 <= rx_s;
        if (edge_cnt_out == pt1) s1 <= rx_s;
        if (edge_cnt_out == pt2) begin
          sampled_bit_out  <= majority3(s0, s1, rx_s);
          sample_valid_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// Self-checking bench for uart_rx_data_sampler.
// Frame vectors with scoreboard, plus abort/reset sequences.
module tb_uart_rx_data_sampler;

  logic       clk;
  logic       reset_n;
  logic       rx_in;
  logic [4:0] prescale_in;
  logic       par_en_in;
  logic       counter_en_in;
  logic       data_sample_en_in;
  logic [4:0] edge_cnt_out;
  logic [3:0] bit_cnt_out;
  logic       sampled_bit_out;
  logic       sample_valid_out;

  int nvec = 0;
  int nerr = 0;
  logic sb[$];

  typedef struct {
    string       name;
    int          pin;
    bit          par;
    logic [31:0] bits;
    int          nbits;
    int          gbit;
    logic [15:0] gmask;
    logic        gexp;
  } vec_t;

  vec_t vecs[8];

  uart_rx_data_sampler dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .rx_in             (rx_in),
    .prescale_in       (prescale_in),
    .par_en_in         (par_en_in),
    .counter_en_in     (counter_en_in),
    .data_sample_en_in (data_sample_en_in),
    .edge_cnt_out      (edge_cnt_out),
    .bit_cnt_out       (bit_cnt_out),
    .sampled_bit_out   (sampled_bit_out),
    .sample_valid_out  (sample_valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] d, input bit par);
    logic [10:0] f;
    f      = 11'h7FF;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (par) f[9] = ^d;
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_bits(input vec_t v);
    int   p, h, last, total, b, e;
    bit   ev;
    logic rxv, exp;
    p     = (v.pin < 4) ? 4 : v.pin;
    h     = p / 2;
    last  = v.par ? 10 : 9;
    total = (v.nbits - 1) * p + h + 3;
    sb.delete();
    prescale_in       = 5'(v.pin);
    par_en_in         = v.par;
    counter_en_in     = 1'b1;
    data_sample_en_in = 1'b1;
    for (int k = 0; k < total; k++) begin
      b   = k / p;
      e   = k % p;
      rxv = (b < v.nbits) ? v.bits[b] : 1'b1;
      if (b == v.gbit && v.gmask[e]) rxv = ~rxv;
      rx_in = rxv;
      if (e == 0 && b < v.nbits)
        sb.push_back((b == v.gbit) ? v.gexp : v.bits[b]);
      check({v.name, "_edge"}, int'(edge_cnt_out), e);
      check({v.name, "_bitcnt"}, int'(bit_cnt_out), b % (last + 1));
      ev = (k >= h + 2) && ((k - h - 2) % p == 0)
        && ((k - h - 2) / p < v.nbits);
      check({v.name, "_valid"}, int'(sample_valid_out), int'(ev));
      if (sample_valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          check({v.name, "_spurious_strobe"}, 1, 0);
        end else begin
          exp = sb.pop_front();
          check({v.name, "_sample"}, int'(sampled_bit_out), int'(exp));
        end
      end
      step();
    end
    counter_en_in     = 1'b0;
    data_sample_en_in = 1'b0;
    rx_in             = 1'b1;
    step();
    check({v.name, "_drain"}, sb.size(), 0);
    check({v.name, "_idle_edge"}, int'(edge_cnt_out), 0);
    check({v.name, "_idle_bit"}, int'(bit_cnt_out), 0);
  endtask

  initial begin
    reset_n           = 1'b0;
    rx_in             = 1'b1;
    prescale_in       = 5'd8;
    par_en_in         = 1'b0;
    counter_en_in     = 1'b0;
    data_sample_en_in = 1'b0;

    vecs[0] = '{"idle", 8, 1'b0, 32'h7FF, 11, -1, 16'h0, 1'b1};
    vecs[1] = '{"a5", 8, 1'b0, 32'(mkframe(8'hA5, 1'b0)), 10, -1, 16'h0, 1'b1};
    vecs[2] = '{"glitch1", 16, 1'b0, 32'(mkframe(8'hFF, 1'b0)), 10, 3,
                16'h0080, 1'b1};
    vecs[3] = '{"glitch2", 16, 1'b0, 32'(mkframe(8'hFF, 1'b0)), 10, 3,
                16'h0180, 1'b0};
    vecs[4] = '{"glitch_lo", 16, 1'b0, 32'(mkframe(8'h00, 1'b0)), 10, 2,
                16'h0200, 1'b0};
    vecs[5] = '{"par_b2b", 16, 1'b1,
                {10'h3FF, mkframe(8'hA5, 1'b1), mkframe(8'h3C, 1'b1)},
                22, -1, 16'h0, 1'b1};
    vecs[6] = '{"clamp", 2, 1'b0, 32'(mkframe(8'h5A, 1'b0)), 10, -1,
                16'h0, 1'b1};
    vecs[7] = '{"p4_par", 4, 1'b1, 32'(mkframe(8'h81, 1'b1)), 11, -1,
                16'h0, 1'b1};

    #12;
    check("rst_edge", int'(edge_cnt_out), 0);
    check("rst_bit", int'(bit_cnt_out), 0);
    check("rst_sample", int'(sampled_bit_out), 1);
    check("rst_valid", int'(sample_valid_out), 0);
    #11 reset_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_bits(vecs[i]);

    // abort: counter_en drops at bit 4, edge 3
    prescale_in       = 5'd8;
    par_en_in         = 1'b0;
    rx_in             = 1'b1;
    counter_en_in     = 1'b1;
    data_sample_en_in = 1'b1;
    for (int k = 0; k < 35; k++) step();
    check("abort_pre_edge", int'(edge_cnt_out), 3);
    check("abort_pre_bit", int'(bit_cnt_out), 4);
    counter_en_in = 1'b0;
    step();
    check("abort_edge", int'(edge_cnt_out), 0);
    check("abort_bit", int'(bit_cnt_out), 0);
    for (int k = 0; k < 12; k++) begin
      check("abort_nostrobe", int'(sample_valid_out), 0);
      check("abort_hold_edge", int'(edge_cnt_out), 0);
      step();
    end
    data_sample_en_in = 1'b0;

    // async reset in the strobe cycle of a low bit
    rx_in             = 1'b0;
    counter_en_in     = 1'b1;
    data_sample_en_in = 1'b1;
    for (int k = 0; k < 14; k++) step();
    check("mid_pre_valid", int'(sample_valid_out), 1);
    check("mid_pre_sample", int'(sampled_bit_out), 0);
    check("mid_pre_bit", int'(bit_cnt_out), 1);
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_edge", int'(edge_cnt_out), 0);
    check("mid_rst_bit", int'(bit_cnt_out), 0);
    check("mid_rst_sample", int'(sampled_bit_out), 1);
    check("mid_rst_valid", int'(sample_valid_out), 0);
    counter_en_in     = 1'b0;
    data_sample_en_in = 1'b0;
    rx_in             = 1'b1;
    #2 reset_n = 1'b1;
    step();

    // clean restart after the reset
    run_bits(vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
